audio_dac_serializer: RTL
=========================

// Module: audio_dac_serializer
// PURPOSE
//  Transmit end of the codec audio path. Accepts processed left/right samples from the DSP path
//  and serializes them to the WM8731 DAC pins: AUD_BCLK, AUD_DACLRCK and AUD_DACDAT.
//  Generates bit and frame timing from one master clock, and emits a per-frame sample_request
//  pulse that paces the DSP path.
// PARAMETERS
//  CLK_DIV      4   audio_clock cycles per BCLK half-period (BCLK = audio_clock/(2*CLK_DIV)); >=2
//  SAMPLE_WIDTH 16  bits per channel sample
//  SLOT_WIDTH   16  BCLKs per channel slot; >= SAMPLE_WIDTH; frame = 2*SLOT_WIDTH BCLKs
// PORTS
//  audio_clock    in  1   master clock; all logic on its rising edge
//  reset          in  1   asynchronous, active-low
//  left_sample    in  16  left channel, two's complement
//  right_sample   in  16  right channel, two's complement
//  sample_valid   in  1   upstream holds a sample pair
//  sample_ready   out 1   pending buffer empty; pair is accepted when valid && ready
//  sample_request out 1   1-clock pulse at each frame load
//  underrun       out 1   1-clock pulse when a frame loads with no new pair (RUN state only)
//  aud_bclk       out 1   bit clock
//  aud_daclrck    out 1   frame/channel select
//  aud_dacdat     out 1   serial data, MSB first
// BEHAVIOUR
//  - Reset values: aud_bclk=0, aud_dacdat=0, aud_daclrck=left level, sample_ready=1,
//    sample_request=0, underrun=0. Divider, bit counter and buffers are cleared. State = IDLE.
//  - Divider: counts 0..CLK_DIV-1. At the wrap, aud_bclk toggles. The toggle 1->0 is a "fall event".
//    The first rising edge of aud_bclk comes CLK_DIV clocks after reset deasserts.
//  - Fall event: bit_cnt increments mod 2*SLOT_WIDTH. Only on this event do aud_dacdat and
//    aud_daclrck change, so they are stable at the BCLK rising edge where the codec samples.
//  - aud_daclrck is the left level while bit_cnt < SLOT_WIDTH, and the right level otherwise.
//  - Slot bits: the sample goes out MSB first. Bits SAMPLE_WIDTH..SLOT_WIDTH-1 of a slot are 0.
//  - Frame load: happens on the fall event where bit_cnt wraps to 0. It does the following:
//     - pending full: copy pending into the shift registers and clear pending.
//     - pending empty and valid high in the same clock: load the inputs directly (bypass).
//       pending stays empty and no underrun is flagged.
//     - otherwise: replay the previous pair. Pulse underrun if in RUN.
//     - sample_request pulses in the same clock.
//  - Handshake: sample_ready = !pending_full. Inputs are captured on valid && ready.
//    Upstream must hold its data while valid=1 and ready=0.
//  - FSM:
//     - IDLE: aud_dacdat=0. The first accepted pair sets the go flag.
//     - IDLE->RUN at the next frame load after go is set; that frame carries the pair.
//     - RUN stays in RUN. Reset is the only exit.
//  - Reset mid-frame: all outputs take their reset values immediately (async) and return to IDLE.
//    The frame in progress is discarded.
// CONFIGURATION
//  DAC_I2S_FORMAT_EN defined: I2S format.
//   - Left level = 0.
//   - aud_dacdat lags by one BCLK through a 1-bit delay register. So the slot MSB appears one
//     BCLK after the aud_daclrck edge, and the right-slot LSB is driven during bit_cnt 0 of the
//     next frame.
//  Undefined: left-justified format.
//   - Left level = 1.
//   - The slot MSB is driven on the same fall event as the aud_daclrck edge. No delay register.
// STRUCTURE
//  - audio_codec_pkg: format constants (FMT_LJ, FMT_I2S), default widths, left-level constants
//    per format, FSM state encoding (ST_IDLE, ST_RUN).
//  - Sub-module audio_bclk_divider: divider counter and aud_bclk register. Outputs fall_evt
//    and rise_evt strobes. The top holds the bit counter, buffers, shifter and FSM.
// TESTING  (CLK_DIV=4, widths 16: BCLK = 8 clocks, frame = 256 clocks)
//  1. Hold reset=0 for 10 clocks. All outputs match the reset values and sample_ready=1.
//     Release reset: first aud_bclk rise at clock 4; sample_request exactly every 256 clocks.
//  2. LJ build, L=16'hA5F0, R=16'h0001. Sampling aud_dacdat at BCLK rises gives A5F0 while
//     aud_daclrck=1, then 0001 while aud_daclrck=0.
//  3. I2S build, same data. Each bit comes one BCLK later. The R LSB (1) is sampled at the first
//     rise of the next frame, with aud_daclrck=0 (left).
//  4. In RUN, supply no pair for one frame. underrun pulses with sample_request, and the
//     previous A5F0/0001 frame repeats bit-exact.
//  5. Offer two pairs back to back. The second sees ready=0 until the next frame load, then is
//     accepted. No pair is lost or duplicated across 4 frames.
//  6. Assert valid with pending empty, in the exact frame-load clock. The pair goes out in that
//     frame, sample_ready stays 1, underrun=0. Then assert reset at bit_cnt 7:
//     aud_dacdat=0 at once and the block is back in IDLE.

Source files
------------

// File: rtl/audio_dac_serializer_pkg.sv
// audio_codec_pkg: format constants, default widths, left levels and FSM encoding for the DAC path
package audio_codec_pkg;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam int DEF_SLOT_WIDTH = 16;
  typedef enum logic {FMT_LJ = 1'b0, FMT_I2S = 1'b1} fmt_e;
  localparam logic LEFT_LVL_LJ = 1'b1;
  localparam logic LEFT_LVL_I2S = 1'b0;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
  function automatic logic left_level(fmt_e f);
    return f == FMT_I2S ? LEFT_LVL_I2S : LEFT_LVL_LJ;
  endfunction
endpackage

// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if: sample pair handshake and frame pacing strobes between DSP path and DAC
interface audio_dac_serializer_if #(
  parameter int W = 16
);
  logic [W-1:0] left_sample;
  logic [W-1:0] right_sample;
  logic sample_valid;
  logic sample_ready;
  logic sample_request;
  logic underrun;
  modport master (
    output left_sample, right_sample, sample_valid,
    input sample_ready, sample_request, underrun
  );
  modport slave (
    input left_sample, right_sample, sample_valid,
    output sample_ready, sample_request, underrun
  );
endinterface

// File: rtl/audio_dac_serializer_bclk_divider.sv
// audio_bclk_divider: divides the master clock into BCLK and flags the cycle before each BCLK edge
module audio_bclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic audio_clock,
  input  logic reset,
  output logic aud_bclk,
  output logic fall_evt,
  output logic rise_evt
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] TOP = DW'(CLK_DIV - 1);
  logic [DW-1:0] cnt;
  logic wrap;
  assign wrap = cnt == TOP;
  assign fall_evt = wrap && aud_bclk;
  assign rise_evt = wrap && !aud_bclk;
  // divider counter; BCLK toggles at every wrap
  always_ff @(posedge audio_clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      aud_bclk <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) aud_bclk <= !aud_bclk;
    end
endmodule

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: WM8731 DAC serializer, left-justified by default, I2S when DAC_I2S_FORMAT_EN is defined
module audio_dac_serializer
  import audio_codec_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH = DEF_SLOT_WIDTH
) (
  input  logic audio_clock,
  input  logic reset,
  audio_dac_serializer_if.slave bus,
  output logic aud_bclk,
  output logic aud_daclrck,
  output logic aud_dacdat
);
`ifdef DAC_I2S_FORMAT_EN
  localparam fmt_e FMT = FMT_I2S;
`else
  localparam fmt_e FMT = FMT_LJ;
`endif
  localparam logic LEFT = left_level(FMT);
  localparam int CW = $clog2(2 * SLOT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * SLOT_WIDTH - 1);
  localparam logic [CW-1:0] SLOT = CW'(SLOT_WIDTH);
  logic fall_evt, unused_rise, load, acc, go, pend_full, tx_en, tx_bit;
  logic [CW-1:0] bit_cnt, nxt_cnt, pos;
  logic [SAMPLE_WIDTH-1:0] pend_l, pend_r, frm_l, frm_r, nxt_l, nxt_r, smp, sh;
  state_e state, state_nxt;
  audio_bclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .audio_clock(audio_clock),
    .reset(reset),
    .aud_bclk(aud_bclk),
    .fall_evt(fall_evt),
    .rise_evt(unused_rise)
  );
  assign bus.sample_ready = !pend_full;
  assign acc = bus.sample_valid && !pend_full;
  assign load = fall_evt && bit_cnt == LAST;
  assign nxt_cnt = bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
  assign nxt_l = !load ? frm_l : pend_full ? pend_l : acc ? bus.left_sample : frm_l;
  assign nxt_r = !load ? frm_r : pend_full ? pend_r : acc ? bus.right_sample : frm_r;
  assign pos = nxt_cnt < SLOT ? nxt_cnt : nxt_cnt - SLOT;
  assign smp = nxt_cnt < SLOT ? nxt_l : nxt_r;
  assign sh = smp << pos;
  assign tx_bit = tx_en && sh[SAMPLE_WIDTH-1];
  // pending buffer, frame pair (kept for replay), go flag and bit counter
  always_ff @(posedge audio_clock or negedge reset)
    if (!reset) begin
      pend_full <= 1'b0;
      pend_l <= '0;
      pend_r <= '0;
      frm_l <= '0;
      frm_r <= '0;
      go <= 1'b0;
      bit_cnt <= '0;
    end else begin
      pend_full <= !load && (pend_full || acc);
      if (acc && !load) begin
        pend_l <= bus.left_sample;
        pend_r <= bus.right_sample;
      end
      frm_l <= nxt_l;
      frm_r <= nxt_r;
      go <= go || acc;
      if (fall_evt) bit_cnt <= nxt_cnt;
    end
`ifdef DAC_I2S_FORMAT_EN
  logic dly;
`endif
  // LRCK and data change only on BCLK falls so they are stable at the codec's sampling edge
  always_ff @(posedge audio_clock or negedge reset)
    if (!reset) begin
      aud_daclrck <= LEFT;
      aud_dacdat <= 1'b0;
`ifdef DAC_I2S_FORMAT_EN
      dly <= 1'b0;
`endif
    end else if (fall_evt) begin
      aud_daclrck <= nxt_cnt < SLOT ? LEFT : !LEFT;
`ifdef DAC_I2S_FORMAT_EN
      dly <= tx_bit;
      aud_dacdat <= dly;
`else
      aud_dacdat <= tx_bit;
`endif
    end
  // FSM state register
  always_ff @(posedge audio_clock or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nxt;
  // IDLE leaves for RUN at the first frame load that has a pair to send
  always_comb state_nxt = (state == ST_IDLE && load && (go || acc)) ? ST_RUN : state;
  // data enable, frame pacing and underrun strobes
  always_comb begin
    tx_en = state == ST_RUN || (load && (go || acc));
    bus.sample_request = load;
    bus.underrun = load && state == ST_RUN && !pend_full && !acc;
  end
endmodule
